imem_loader: RTL and testbench

Parametrised, run-time loadable instruction memory for the single-cycle/multicycle CPU datapath. The contents are not baked in at elaboration. After reset the block clears itself to NOP words. It then accepts a program over a valid/ready load stream from the host/UART loader and serves registered instruction fetches to the PC stage. `busy` stalls the CPU while the memory is being cleared or loaded.

---
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Run-time loadable instruction memory: clears itself to NOP after reset, takes a
// program over a valid/ready stream, then serves registered instruction fetches.
module imem_loader #(
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 64,
    parameter int          ADDR_W   = $clog2(DEPTH),
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_overflow,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_err,
    output logic              busy
);

    localparam logic [ADDR_W:0]   DEPTH_P = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_P  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [DATA_W-1:0] NOP_P   = DATA_W'(NOP_WORD);

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        RUN
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              room;
    logic              in_range;

    assign room     = (ptr < DEPTH_P);
    assign in_range = ({1'b0, fetch_addr} < DEPTH_P);

    // Single write port shared by the clear sweep and the program load.
    always_comb begin
        we    = 1'b0;
        waddr = ptr[ADDR_W-1:0];
        wdata = NOP_P;
        if (!rst) begin
            case (state)
                CLEAR: we = 1'b1;
                LOAD: begin
                    we    = ld_valid && room;
                    wdata = ld_data;
                end
                default: we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            ptr         <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
            busy        <= 1'b1;
            ld_ready    <= 1'b0;
            ld_count    <= '0;
            ld_overflow <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
            case (state)
                CLEAR: begin
                    if (ptr == LAST_P) begin
                        state <= RUN;
                        ptr   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        if (room) begin
                            ptr      <= ptr + 1'b1;
                            ld_count <= ld_count + 1'b1;
                        end else begin
                            ld_overflow <= 1'b1;
                        end
                        if (ld_last) begin
                            state    <= RUN;
                            ld_ready <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // A load request wins over a same-cycle fetch, which is dropped.
                    if (ld_start) begin
                        state       <= LOAD;
                        ptr         <= '0;
                        ld_count    <= '0;
                        ld_overflow <= 1'b0;
                        ld_ready    <= 1'b1;
                        busy        <= 1'b1;
                    end else if (fetch_req) begin
                        instr_valid <= 1'b1;
                        if (in_range) begin
                            instr    <= mem[fetch_addr];
                            addr_err <= 1'b0;
                        end else begin
                            instr    <= NOP_P;
                            addr_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a word-array reference model predicts fetch results,
// and an independent monitor pops and compares them whenever instr_valid is seen.
module tb_imem_loader;

    localparam int          DEPTH = 48;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h00000000;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          ld_start;
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic [AW:0]   ld_count;
    logic          ld_overflow;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          addr_err;
    logic          busy;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] refMem [DEPTH];
    int          refCount;
    bit          refOverflow;
    exp_t        sb[$];
    logic [31:0] prog[$];

    imem_loader #(
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .NOP_WORD(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_count   (ld_count),
        .ld_overflow(ld_overflow),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .instr      (instr),
        .instr_valid(instr_valid),
        .addr_err   (addr_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Holds reset, checks reset values, then times the clear sweep edge by edge.
    task automatic doReset(input int cycles);
        rst       = 1'b1;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        fetch_req = 1'b0;
        repeat (cycles) tick();
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_ld_ready", ld_ready, 0);
        checkOutput("rst_ld_count", ld_count, 0);
        checkOutput("rst_ld_overflow", ld_overflow, 0);
        checkOutput("rst_instr", instr, 0);
        checkOutput("rst_instr_valid", instr_valid, 0);
        checkOutput("rst_addr_err", addr_err, 0);
        rst = 1'b0;
        foreach (refMem[i]) refMem[i] = NOP;
        refCount    = 0;
        refOverflow = 0;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            checkOutput("busy_clear", busy, (k < DEPTH) ? 1 : 0);
        end
    endtask

    task automatic doFetch(input int addr);
        exp_t e;
        e.data     = (addr < DEPTH) ? refMem[addr] : NOP;
        e.err      = (addr >= DEPTH);
        fetch_req  = 1'b1;
        fetch_addr = AW'(addr);
        sb.push_back(e);
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic doLoad(input int n, input bit withLast, input bit withFetch, input int gapAt);
        ld_start = 1'b1;
        if (withFetch) begin
            fetch_req  = 1'b1;
            fetch_addr = '0;
        end
        tick();
        ld_start  = 1'b0;
        fetch_req = 1'b0;
        refCount    = 0;
        refOverflow = 0;
        checkOutput("ld_ready_rise", ld_ready, 1);
        checkOutput("busy_load", busy, 1);
        checkOutput("ld_count_start", ld_count, 0);
        if (withFetch) checkOutput("dropped_fetch", instr_valid, 0);
        for (int i = 0; i < n; i++) begin
            if (i == gapAt) begin
                ld_valid = 1'b0;
                repeat (3) begin
                    tick();
                    checkOutput("ld_count_gap", ld_count, refCount);
                end
            end
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = withLast && (i == n - 1);
            if (refCount < DEPTH) begin
                refMem[refCount] = prog[i];
                refCount++;
            end else begin
                refOverflow = 1;
            end
            tick();
            checkOutput("ld_count_step", ld_count, refCount);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (withLast) begin
            checkOutput("ld_ready_fall", ld_ready, 0);
            checkOutput("busy_run", busy, 0);
            checkOutput("ld_overflow", ld_overflow, refOverflow);
        end
    endtask

    task automatic randomProgram(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back($urandom);
    endtask

    task automatic applyStimulus();
        doReset(2);
        for (int a = 0; a < DEPTH; a++) doFetch(a);

        prog = '{32'h80088014, 32'h8010800F, 32'h80188004, 32'h00000000, 32'h04208200};
        doLoad(5, 1, 0, -1);
        checkOutput("ld_count_plan", ld_count, 5);
        for (int a = 0; a < 5; a++) doFetch(a);

        randomProgram(12);
        doLoad(12, 1, 0, 4);
        repeat (20) doFetch($urandom_range(0, 63));

        randomProgram(DEPTH + 2);
        doLoad(DEPTH + 2, 1, 0, -1);
        checkOutput("ovf_flag", ld_overflow, 1);
        checkOutput("ovf_count", ld_count, DEPTH);
        for (int a = 0; a < DEPTH; a++) doFetch(a);
        doFetch(DEPTH - 1);
        doFetch(DEPTH + 2);

        randomProgram(3);
        doLoad(3, 1, 1, -1);
        for (int a = 0; a < 4; a++) doFetch(a);

        randomProgram(3);
        doLoad(3, 0, 0, -1);
        doReset(1);
        for (int a = 0; a < 3; a++) doFetch(a);

        repeat (20) doFetch($urandom_range(0, 63));
        repeat (3) tick();
        checkOutput("sb_drained", sb.size(), 0);
    endtask

    // Monitor: every instr_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (instr_valid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_valid: got instr_valid=1 instr=%0h, expected no result", instr);
                end else begin
                    e = sb.pop_front();
                    checkOutput("fetch_instr", instr, e.data);
                    checkOutput("fetch_err", addr_err, e.err);
                end
            end else if (addr_err) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL stray_addr_err: got addr_err=1, expected 0 without instr_valid");
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        ld_start   = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        ld_last    = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        applyStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
